// File: rtl/ans_tx_pkg.sv
// Shared types and helpers for the OFDM training-field generator: FSM states,
// per-bin obfuscation scaling codes and the saturating output shift.
package ans_tx_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAP, PLAY} state_t;

  localparam logic [1:0] SC_X1 = 2'b00;
  localparam logic [1:0] SC_D8 = 2'b01;
  localparam logic [1:0] SC_D2 = 2'b10;
  localparam logic [1:0] SC_D4 = 2'b11;

  // x is one component sign-extended to 32 bits; the result holds the clamped
  // value, of which the caller keeps the low iw bits.
  function automatic logic signed [31:0] sat_shift(input logic signed [31:0] x,
                                                   input int unsigned sh,
                                                   input int unsigned iw);
    logic signed [34:0] y;
    logic signed [34:0] maxv;
    logic signed [34:0] minv;
    y    = 35'(x) <<< sh;
    maxv = (35'sd1 <<< (iw - 1)) - 35'sd1;
    minv = -(35'sd1 <<< (iw - 1));
    if (y > maxv)      return 32'(maxv);
    else if (y < minv) return 32'(minv);
    else               return 32'(y);
  endfunction

endpackage

// File: rtl/ans_train_field_gen_if.sv
// Valid/ready sample stream from the training-field generator to the tx mux.
interface ans_train_field_gen_if #(parameter int unsigned DW = 32) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ans_sym_buf.sv
// One-symbol time-domain sample buffer: single-port RAM with registered read.
module ans_sym_buf #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ans_train_field_gen.sv
// OFDM training-field generator: ROM -> obfuscation scaling -> external IFFT,
// captures one symbol, then streams cyclic prefix plus n_sym repeated symbols.
module ans_train_field_gen
  import ans_tx_pkg::*;
#(
  parameter int unsigned LGN       = 6,
  parameter int unsigned IW        = 16,
  parameter int unsigned OUT_SHIFT = 1,
  parameter int unsigned SYMW      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LGN-1:0]        cp_len,
  input  logic [SYMW-1:0]       n_sym,
  input  logic [(2<<LGN)-1:0]   obf_coeff,
  output logic [LGN-1:0]        rom_addr,
  input  logic [2*IW-1:0]       rom_data,
  output logic                  ifft_ce,
  output logic [2*IW-1:0]       ifft_in,
  input  logic [2*IW-1:0]       ifft_out,
  input  logic                  ifft_sync,
  ans_train_field_gen_if.master o,
  output logic                  busy,
  output logic                  started,
  output logic                  done
);

  localparam int unsigned CW = LGN + SYMW;

  state_t              state, state_nx;
  logic [LGN-1:0]      k, idx, cp_q;
  logic [SYMW-1:0]     nsym_q;
  logic [(2<<LGN)-1:0] coeff_q;
  logic [CW-1:0]       left;
  logic                vld, first, done_q, hs;

  logic                buf_we;
  logic [LGN-1:0]      buf_addr;
  logic [2*IW-1:0]     buf_rdata;

  logic signed [IW-1:0] ri, rq, bi, bq;
  logic signed [31:0]   si, sq;
  logic [1:0]           code, sh;

  assign hs = vld & o.tready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)                state_nx = LOAD;
      LOAD:    if (&k)                   state_nx = WAIT;
      WAIT:    if (ifft_sync)            state_nx = CAP;
      CAP:     if (&k)                   state_nx = PLAY;
      PLAY:    if (hs && left == '0)     state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_comb begin
    code = coeff_q[{k, 1'b0} +: 2];
    unique case (code)
      SC_D8:   sh = 2'd3;
      SC_D2:   sh = 2'd1;
      SC_D4:   sh = 2'd2;
      SC_X1:   sh = 2'd0;
      default: sh = 2'd0;
    endcase
    ri = rom_data[2*IW-1:IW];
    rq = rom_data[IW-1:0];

    rom_addr = '0;
    ifft_in  = '0;
    ifft_ce  = 1'b0;
    buf_we   = 1'b0;
    buf_addr = idx;
    unique case (state)
      LOAD: begin
        ifft_ce  = 1'b1;
        rom_addr = k;
        ifft_in  = {ri >>> sh, rq >>> sh};
      end
      WAIT: begin
        ifft_ce  = 1'b1;
        buf_we   = ifft_sync;
        buf_addr = '0;
      end
      CAP: begin
        ifft_ce  = 1'b1;
        buf_we   = 1'b1;
        buf_addr = k;
      end
      // Read one index ahead on acceptance so the next sample is ready with no
      // bubble; a stalled beat keeps re-reading the same address.
      PLAY:    buf_addr = hs ? idx + 1'b1 : idx;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k       <= '0;
      idx     <= '0;
      left    <= '0;
      cp_q    <= '0;
      nsym_q  <= '0;
      coeff_q <= '0;
      vld     <= 1'b0;
      first   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        k     <= '0;
        vld   <= 1'b0;
        first <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            cp_q    <= cp_len;
            nsym_q  <= (n_sym == '0) ? SYMW'(1) : n_sym;
            coeff_q <= obf_coeff;
            k       <= '0;
          end
          LOAD: k <= k + 1'b1;
          WAIT: if (ifft_sync) k <= LGN'(1);
          CAP: begin
            k <= k + 1'b1;
            if (&k) begin
              // Prefix start index wraps to 0 when cp_len is 0.
              idx   <= '0 - cp_q;
              left  <= CW'(cp_q) + (CW'(nsym_q) << LGN) - 1'b1;
              first <= 1'b1;
            end
          end
          PLAY: begin
            if (hs) begin
              first <= 1'b0;
              if (left == '0) begin
                vld    <= 1'b0;
                done_q <= 1'b1;
              end else begin
                left <= left - 1'b1;
                idx  <= idx + 1'b1;
              end
            end else begin
              vld <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ans_sym_buf #(.AW(LGN), .DW(2*IW)) u_sym_buf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (ifft_out),
    .rdata (buf_rdata)
  );

  always_comb begin
    bi = buf_rdata[2*IW-1:IW];
    bq = buf_rdata[IW-1:0];
    si = sat_shift(32'(bi), OUT_SHIFT, IW);
    sq = sat_shift(32'(bq), OUT_SHIFT, IW);
  end

  assign o.tdata  = {si[IW-1:0], sq[IW-1:0]};
  assign o.tvalid = vld;
  assign busy     = (state != IDLE);
  assign started  = hs & first;
  assign done     = done_q;

endmodule

// File: tb/tb_ans_train_field_gen.sv
// Bench for ans_train_field_gen: directed fields on an LGN=6 instance plus a
// saturating LGN=7/OUT_SHIFT=3 instance, checked by an output scoreboard.
module tb_ans_train_field_gen;

  localparam int NA = 64;
  localparam int NB = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: LGN=6, OUT_SHIFT=0
  logic         start_a = 1'b0, abort_a = 1'b0;
  logic [5:0]   cp_a = '0;
  logic [2:0]   ns_a = '0;
  logic [127:0] coeff_a = '0;
  logic [5:0]   rom_addr_a;
  logic [31:0]  rom_data_a, ifft_in_a, ifft_out_a;
  logic         ifft_ce_a, ifft_sync_a, busy_a, started_a, done_a;
  ans_train_field_gen_if #(.DW(32)) if_a ();

  ans_train_field_gen #(.LGN(6), .IW(16), .OUT_SHIFT(0), .SYMW(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .cp_len(cp_a), .n_sym(ns_a), .obf_coeff(coeff_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .ifft_ce(ifft_ce_a), .ifft_in(ifft_in_a), .ifft_out(ifft_out_a), .ifft_sync(ifft_sync_a),
    .o(if_a), .busy(busy_a), .started(started_a), .done(done_a));

  // ---------------- instance B: LGN=7, OUT_SHIFT=3
  logic         start_b = 1'b0, abort_b = 1'b0;
  logic [6:0]   cp_b = '0;
  logic [2:0]   ns_b = '0;
  logic [255:0] coeff_b = '0;
  logic [6:0]   rom_addr_b;
  logic [31:0]  rom_data_b, ifft_in_b, ifft_out_b;
  logic         ifft_ce_b, ifft_sync_b, busy_b, started_b, done_b;
  ans_train_field_gen_if #(.DW(32)) if_b ();

  ans_train_field_gen #(.LGN(7), .IW(16), .OUT_SHIFT(3), .SYMW(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .cp_len(cp_b), .n_sym(ns_b), .obf_coeff(coeff_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .ifft_ce(ifft_ce_b), .ifft_in(ifft_in_b), .ifft_out(ifft_out_b), .ifft_sync(ifft_sync_b),
    .o(if_b), .busy(busy_b), .started(started_b), .done(done_b));

  // ROM word b = {b<<8, -(b<<8)}
  function automatic logic [31:0] rom_word(input int b);
    logic [15:0] p, m;
    p = 16'(b * 256);
    m = 16'(-(b * 256));
    return {p, m};
  endfunction

  assign rom_data_a = rom_word(int'(rom_addr_a));
  assign rom_data_b = rom_word(int'(rom_addr_b));

  // IFFT stubs: identity transform, first output sample 5 cycles after the
  // last input of a frame; sync marks the sample entered on the rising ifft_ce.
  logic [32:0] dl_a [NA+4];
  logic [32:0] dl_b [NB+4];
  logic        ce_d_a, ce_d_b;

  always @(posedge clk) begin
    if (!reset_n) begin
      ce_d_a <= 1'b0;
      for (int i = 0; i < NA + 4; i++) dl_a[i] <= '0;
    end else begin
      ce_d_a <= ifft_ce_a;
      if (ifft_ce_a) begin
        for (int i = NA + 3; i > 0; i--) dl_a[i] <= dl_a[i-1];
        dl_a[0] <= {ifft_ce_a & ~ce_d_a, ifft_in_a};
      end
    end
  end
  assign ifft_out_a  = dl_a[NA+3][31:0];
  assign ifft_sync_a = dl_a[NA+3][32] & ifft_ce_a;

  always @(posedge clk) begin
    if (!reset_n) begin
      ce_d_b <= 1'b0;
      for (int i = 0; i < NB + 4; i++) dl_b[i] <= '0;
    end else begin
      ce_d_b <= ifft_ce_b;
      if (ifft_ce_b) begin
        for (int i = NB + 3; i > 0; i--) dl_b[i] <= dl_b[i-1];
        dl_b[0] <= {ifft_ce_b & ~ce_d_b, ifft_in_b};
      end
    end
  end
  assign ifft_out_b  = dl_b[NB+3][31:0];
  assign ifft_sync_b = dl_b[NB+3][32] & ifft_ce_b;

  // ---------------- scoreboard state
  int errors = 0;
  int checks = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] cap_a [512];
  logic [31:0] cap_b [512];
  int beats_a, beats_b, done_cnt_a, done_cnt_b, started_cnt_a;
  int done_cyc_a, last_beat_cyc_a;
  logic hold_a;
  logic [31:0] held_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference component: divide by the bin's factor rounding toward -inf,
  // multiply by 2**sh_out, clamp to the 16-bit signed range.
  function automatic logic [15:0] model_comp(input logic [15:0] raw, input logic [1:0] code,
                                             input int sh_out);
    int v, d;
    v = int'($signed(raw));
    case (code)
      2'b01:   d = 8;
      2'b10:   d = 2;
      2'b11:   d = 4;
      default: d = 1;
    endcase
    v = (v >= 0) ? v / d : -((-v + d - 1) / d);
    v = v * (1 << sh_out);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic push_field(input int inst, input int cp, input int nsym, input logic [255:0] coeff);
    int n, sh, ns, b;
    logic [31:0] w, e;
    logic [1:0] c;
    n  = inst ? NB : NA;
    sh = inst ? 3 : 0;
    ns = (nsym == 0) ? 1 : nsym;
    for (int j = 0; j < cp + ns * n; j++) begin
      b = (j < cp) ? (n - cp + j) : ((j - cp) % n);
      w = rom_word(b);
      c = coeff[2*b +: 2];
      e = {model_comp(w[31:16], c, sh), model_comp(w[15:0], c, sh)};
      if (inst != 0) qb.push_back(e);
      else           qa.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    beats_a = 0; beats_b = 0; done_cnt_a = 0; done_cnt_b = 0; started_cnt_a = 0;
  endtask

  task automatic start_a_field(input int cp, input int nsym, input logic [127:0] coeff);
    clr_counts();
    push_field(0, cp, nsym, {128'b0, coeff});
    cp_a = 6'(cp); ns_a = 3'(nsym); coeff_a = coeff;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done(input int inst, input bit rnd);
    int t;
    t = 0;
    while (((inst != 0) ? done_cnt_b : done_cnt_a) == 0 && t < 5000) begin
      if (rnd) if_a.tready = 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    if_a.tready = 1'b1;
    check("done_within_budget", ((inst != 0) ? done_cnt_b : done_cnt_a) != 0, 1);
    repeat (4) tick();
  endtask

  task automatic end_field_a(input int exp_beats);
    check("beat_count", beats_a, exp_beats);
    check("done_once", done_cnt_a, 1);
    check("started_once", started_cnt_a, 1);
    check("done_after_last_beat", done_cyc_a - last_beat_cyc_a, 1);
    check("queue_drained", qa.size(), 0);
  endtask

  initial begin
    int t;
    if_a.tready = 1'b1;
    if_b.tready = 1'b1;
    hold_a = 1'b0;
    held_a = '0;
    clr_counts();

    fork
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          hold_a = 1'b0;
        end else begin
          if (hold_a && if_a.tvalid) check("stall_hold", if_a.tdata, held_a);
          if (if_a.tvalid && if_a.tready) begin
            check("expected_pending_a", qa.size() != 0, 1);
            if (qa.size() != 0) check("beat_a", if_a.tdata, qa.pop_front());
            if (beats_a < 512) cap_a[beats_a] = if_a.tdata;
            beats_a++;
            last_beat_cyc_a = cyc;
          end
          hold_a = if_a.tvalid && !if_a.tready;
          held_a = if_a.tdata;
          if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
          if (started_a) started_cnt_a++;
          if (if_b.tvalid && if_b.tready) begin
            check("expected_pending_b", qb.size() != 0, 1);
            if (qb.size() != 0) check("beat_b", if_b.tdata, qb.pop_front());
            if (beats_b < 512) cap_b[beats_b] = if_b.tdata;
            beats_b++;
          end
          if (done_b) done_cnt_b++;
        end
      end
    join_none

    // reset state
    repeat (3) tick();
    check("rst_busy", busy_a, 0);
    check("rst_tvalid", if_a.tvalid, 0);
    check("rst_ifft_ce", ifft_ce_a, 0);
    check("rst_done", done_a, 0);
    check("rst_started", started_a, 0);
    check("rst_rom_addr", rom_addr_a, 0);
    check("rst_ifft_in", ifft_in_a, 0);
    reset_n = 1'b1;
    tick();

    // plain field: cp 16, one symbol
    start_a_field(16, 1, '0);
    wait_done(0, 1'b0);
    end_field_a(80);
    check("f1_beat0", cap_a[0], 32'h3000_D000);
    check("f1_beat16_idx0", cap_a[16], 32'h0000_0000);

    // obfuscation codes on bins 2 (01) and 3 (11)
    start_a_field(16, 1, 128'h0000_0000_0000_0000_0000_0000_0000_00D0);
    wait_done(0, 1'b0);
    end_field_a(80);
    check("f2_idx2", cap_a[18], 32'h0040_FFC0);
    check("f2_idx3", cap_a[19], 32'h00C0_FF40);

    // cp 32, two symbols, random backpressure
    start_a_field(32, 2, '0);
    wait_done(0, 1'b1);
    end_field_a(160);

    // start and abort together in IDLE
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("start_abort_idle", busy_a, 0);
    tick();
    check("start_abort_idle_ce", ifft_ce_a, 0);

    // abort during capture
    clr_counts();
    cp_a = 6'd16; ns_a = 3'd1; coeff_a = '0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (90) tick();
    check("pre_abort_busy", busy_a, 1);
    check("pre_abort_ce", ifft_ce_a, 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_ce", ifft_ce_a, 0);
    repeat (200) tick();
    check("abort_no_done", done_cnt_a, 0);
    check("abort_no_beats", beats_a, 0);
    start_a_field(16, 1, '0);
    wait_done(0, 1'b0);
    end_field_a(80);

    // start while playing is ignored
    start_a_field(16, 1, '0);
    t = 0;
    while (beats_a < 10 && t < 2000) begin tick(); t++; end
    check("play_reached", beats_a >= 10, 1);
    cp_a = 6'd0; ns_a = 3'd3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 1'b0);
    end_field_a(80);

    // reset in the middle of playback
    start_a_field(16, 1, '0);
    t = 0;
    while (beats_a < 20 && t < 2000) begin tick(); t++; end
    check("play_reached_rst", beats_a >= 20, 1);
    reset_n = 1'b0;
    tick();
    check("rst_play_tvalid", if_a.tvalid, 0);
    check("rst_play_busy", busy_a, 0);
    qa.delete();
    reset_n = 1'b1;
    tick();

    // saturating instance: LGN 7, OUT_SHIFT 3, no prefix
    clr_counts();
    push_field(1, 0, 1, '0);
    cp_b = '0; ns_b = 3'd1; coeff_b = '0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1, 1'b0);
    check("b_beat_count", beats_b, 128);
    check("b_done_once", done_cnt_b, 1);
    check("b_queue_drained", qb.size(), 0);
    check("b_idx1", cap_b[1], 32'h0800_F800);
    check("b_idx7f_sat", cap_b[127], 32'h7FFF_8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ans_train_field_gen.md
Name: ans_train_field_gen

Overview:
- Parametrised successor to the fixed-size HT-STF/HT-LTF generators. Any OFDM training field of the form cyclic prefix + k repeated IFFT symbols (L-LTF, HT-STF, HT-LTF) comes from one instance.
- Loads the frequency coefficients from a ROM and applies the 2-bit per-subcarrier obfuscation scaling. It drives an external streaming IFFT, captures one time-domain symbol into an internal buffer, then replays the prefix and symbols.
- Output is a valid/ready stream feeding the dot11_tx output mux.

Parameters:
- LGN, 6, log2 of FFT size N (N = 2**LGN).
- IW, 16, bits per I or Q component; samples are 2*IW, with I in the upper half.
- OUT_SHIFT, 1, left shift applied at the output, range 0..3, saturating.
- SYMW, 3, width of the n_sym input.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, active-low, synchronous
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  return to IDLE next cycle from any state
- cp_len  in  LGN  prefix length in samples (0..N-1); latched at start
- n_sym  in  SYMW  number of full symbols (1..2**SYMW-1); latched at start; 0 is treated as 1
- obf_coeff  in  2*N  2-bit scaling code per bin; bin b uses bits [2b+1:2b]; latched at start
- rom_addr  out  LGN  frequency ROM address (asynchronous-read ROM)
- rom_data  in  2*IW  ROM word for rom_addr, same cycle
- ifft_ce  out  1  IFFT clock enable
- ifft_in  out  2*IW  IFFT input sample
- ifft_out  in  2*IW  IFFT output sample
- ifft_sync  in  1  IFFT marks its first output sample
- o_tdata  out  2*IW  output sample
- o_tvalid  out  1  output valid
- o_tready  in  1  downstream ready
- busy  out  1  high in any state other than IDLE
- started  out  1  high for one cycle on the first o_tvalid&&o_tready of a field
- done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, all counters 0, ifft_ce=0, o_tvalid=0, busy=0, started=0, done=0, rom_addr=0, ifft_in=0. The o_tdata value is don't-care.
- IDLE: on start, latch cp_len, n_sym and obf_coeff; counter k=0; go to LOAD.
- LOAD (N cycles): ifft_ce=1, rom_addr=k, ifft_in=scale(rom_data, code[k]). After k=N-1, go to WAIT.
- scale() applies per component, as an arithmetic right shift:
  - code 00: x1
  - code 01: shift right 3
  - code 10: shift right 1
  - code 11: shift right 2
- WAIT: ifft_ce=1, ifft_in=0. When ifft_sync=1, write ifft_out to buf[0], set k=1, go to CAP.
- CAP: ifft_ce=1 and ifft_in=0 each cycle; write ifft_out to buf[k]. After k=N-1, set ifft_ce=0 and go to PLAY.
- PLAY: the output index sequence is:
  - prefix indices N-cp_len .. N-1 (skipped if cp_len=0);
  - then indices 0..N-1, repeated n_sym times.
- PLAY timing and handshake:
  - The first sample is presented one cycle after entering PLAY (one-cycle buffer read latency).
  - o_tvalid stays high until the final beat. o_tdata must be stable while o_tvalid && !o_tready.
  - The index advances only on o_tvalid && o_tready.
  - Length L = cp_len + n_sym*N beats. After beat L is accepted: o_tvalid=0, done=1 for one cycle, go to IDLE.
- Output scaling per component: sat(x << OUT_SHIFT). If the discarded high bits are not all equal to the result sign, clamp to 0x7FFF (positive) or 0x8000 (negative).
- start while busy: ignored.
- start and abort in the same cycle from IDLE: abort wins; stay in IDLE.
- abort: next state IDLE, ifft_ce=0, o_tvalid=0, no done pulse. The external IFFT is not reset; the next LOAD relies on ifft_sync to realign.
- ifft_sync during LOAD: ignored. Only the first sync seen in WAIT is used.
- buf: N x 2*IW single-port RAM, written in CAP and read in PLAY. No read/write overlap.

Decomposition:
- Shared package ans_tx_pkg holds:
  - the state encoding (IDLE, LOAD, WAIT, CAP, PLAY);
  - the scaling codes SC_X1=2'b00, SC_D8=2'b01, SC_D2=2'b10, SC_D4=2'b11;
  - the sat_shift function.
- One natural sub-module, ans_sym_buf: a parametrised N x 2*IW RAM with registered read (1-cycle latency).

Test Plan:
- The bench uses an IFFT stub that passes ifft_in through with 5-cycle latency and pulses sync on the first sample. The ROM holds word b = {b<<8, -(b<<8)}.
- LGN=6, OUT_SHIFT=0, coeff all 00, cp_len=16, n_sym=1, o_tready=1 -> 80 beats: indices 48..63 then 0..63. Beat 0 = {0x3000, 0xD000}. done pulses once, the cycle after beat 80.
- Same field with coeff bin 2 = 01 and bin 3 = 11 -> index 2 outputs {0x0040, 0xFFC0}; index 3 outputs {0x00C0, 0xFF40}.
- cp_len=32, n_sym=2, with o_tready toggled at random -> 160 beats, no drop or duplicate. o_tdata is held stable whenever stalled.
- OUT_SHIFT=3, index 0x7F word {0x7F00, 0x8100} -> output {0x7FFF, 0x8000} (saturated).
- abort asserted in CAP -> IDLE next cycle, ifft_ce=0, no done. A following start produces a correct 80-beat field.
- start asserted during PLAY -> ignored; beat count unchanged. reset_n=0 mid-PLAY -> o_tvalid=0 and busy=0 on the next edge.
